// File: rtl/apb_wait_mem.sv
// APB slave memory with configurable wait states and error checking.
// Ports: APB PCLK/PRESETn, PSELx/PENABLE/PWRITE/PADDR/PWDATA/PSTRB in; PRDATA/PREADY/PSLVERR out.
module apb_wait_mem #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 64,
    parameter int                MEM_SIZE_K  = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0,
    parameter int                RO_BYTES    = 0
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSELx,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int LANE_W    = $clog2(STRB_W);
    localparam int MEM_BYTES = MEM_SIZE_K * 1024;
    localparam int DEPTH     = MEM_BYTES / STRB_W;
    localparam int IDX_W     = $clog2(DEPTH);

    // One extra bit so a window ending at the top of the address space still works.
    localparam logic [ADDR_W:0] LIMIT =
        {1'b0, BASE_ADDR} + (ADDR_W+1)'(MEM_BYTES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic               wr_q;
    logic               err_q;
    logic               ready_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  rd_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0]  offset;
    logic [IDX_W-1:0]   idx_d;
    logic               below;
    logic               above;
    logic               oor;
    logic               mis;
    logic               ro_hit;
    logic               setup;
    logic               complete;
    logic               do_write;
    logic               unused_offset;

    assign offset = PADDR - BASE_ADDR;
    assign idx_d  = offset[IDX_W+LANE_W-1:LANE_W];

    assign unused_offset =
        ^{offset[ADDR_W-1:IDX_W+LANE_W], offset[LANE_W-1:0]};

    // Constant-zero bounds get their own branch so no always-false compare is built.
    if (BASE_ADDR == '0) begin : g_no_below
        assign below = 1'b0;
    end else begin : g_below
        assign below = PADDR < BASE_ADDR;
    end

    if (RO_BYTES == 0) begin : g_no_ro
        assign ro_hit = 1'b0;
    end else begin : g_ro
        assign ro_hit = offset < ADDR_W'(RO_BYTES);
    end

    assign above = {1'b0, PADDR} >= LIMIT;
    assign oor   = below | above;
    assign mis   = |PADDR[LANE_W-1:0];

    assign setup    = (state == IDLE) && PSELx && !PENABLE;
    assign complete = (state == ACCESS) && PSELx && (cnt == 4'd0);
    assign do_write = complete && wr_q && !err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (setup) begin
                        state   <= ACCESS;
                        cnt     <= 4'(WAIT_STATES);
                        ready_q <= (WAIT_STATES == 0);
                        wr_q    <= PWRITE;
                        err_q   <= oor | mis | (PWRITE & ro_hit);
                        idx_q   <= idx_d;
                    end
                end
                ACCESS: begin
                    if (!PSELx || cnt == 4'd0) begin
                        state   <= IDLE;
                        cnt     <= 4'd0;
                        ready_q <= 1'b0;
                    end else begin
                        cnt     <= cnt - 4'd1;
                        ready_q <= (cnt == 4'd1);
                    end
                end
            endcase
        end
    end

    // Storage is never reset; the read is launched at the setup edge.
    always_ff @(posedge PCLK) begin
        if (setup) begin
            rd_q <= mem[idx_d];
        end
        if (do_write) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (PSTRB[b]) begin
                    mem[idx_q][b*8 +: 8] <= PWDATA[b*8 +: 8];
                end
            end
        end
    end

    // Gating with PSELx keeps an aborted completing cycle silent.
    assign PREADY  = ready_q & PSELx;
    assign PSLVERR = PREADY & err_q;
    assign PRDATA  = (PREADY && !err_q && !wr_q) ? rd_q : '0;

endmodule

// File: doc/apb_wait_mem.md
APB_WAIT_MEM -- requirements
Module: apb_wait_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width; legal values 32 and 64 only.
REQ-003 SHALL have parameter MEM_SIZE_K, default 64, memory size in KiB; power of two.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of the first memory location; aligned to MEM_SIZE_K*1024.
REQ-005 SHALL have parameter WAIT_STATES, default 0, PREADY-low cycles per access; range 0..15.
REQ-006 SHALL have parameter RO_BYTES, default 0, size in bytes of the read-only window at offset 0; multiple of DATA_W/8.
REQ-007 SHALL have port PCLK, input, 1, the only clock; all state changes on its rising edge.
REQ-008 SHALL have port PRESETn, input, 1, reset; asynchronous assertion, active-low.
REQ-009 SHALL have port PSELx, input, 1, slave select.
REQ-010 SHALL have port PENABLE, input, 1, access-phase indicator.
REQ-011 SHALL have port PWRITE, input, 1, 1 = write, 0 = read.
REQ-012 SHALL have port PADDR, input, ADDR_W, byte address.
REQ-013 SHALL have port PWDATA, input, DATA_W, write data.
REQ-014 SHALL have port PSTRB, input, DATA_W/8, write byte-lane enables.
REQ-015 SHALL have port PRDATA, output, DATA_W, read data.
REQ-016 SHALL have port PREADY, output, 1, transfer complete.
REQ-017 SHALL have port PSLVERR, output, 1, transfer error.

Function
REQ-018 SHALL implement FSM states IDLE and ACCESS, plus a 4-bit wait counter.
REQ-019 IDLE: PSELx=1 and PENABLE=0 (setup) SHALL go to ACCESS, latch address, direction and error flags, and load counter=WAIT_STATES.
REQ-020 IDLE: PSELx=1 with PENABLE=1 SHALL be ignored (no transfer); FSM stays IDLE.
REQ-021 ACCESS: counter != 0 SHALL give PREADY=0 and decrement the counter each cycle.
REQ-022 ACCESS: counter == 0 SHALL give PREADY=1 (completing cycle); next state IDLE.
- Total access phase = WAIT_STATES+1 cycles.
REQ-023 Back-to-back setup directly after a completing cycle SHALL be accepted with no idle cycle in between.
REQ-024 PSELx=0 in ACCESS SHALL abort the transfer: back to IDLE, no memory write, PREADY=0.
REQ-025 Memory SHALL be a word array of MEM_SIZE_K*1024/(DATA_W/8) entries, indexed by (PADDR-BASE_ADDR)>>log2(DATA_W/8).
- Subtraction is done at ADDR_W bits; the index is then truncated.
REQ-026 Read SHALL be issued at the setup edge, so data is ready in the first access cycle for any WAIT_STATES.
REQ-027 PRDATA SHALL equal the addressed word only in the completing cycle of an error-free read; 0 at all other times.
REQ-028 An error-free write SHALL update only the byte lanes with PSTRB=1, on the completing edge only.
- PSTRB=0 writes nothing and is not an error.
- PSTRB is ignored on reads.
REQ-029 Error flags SHALL be evaluated at setup:
- out-of-range: PADDR < BASE_ADDR or PADDR >= BASE_ADDR+MEM_SIZE_K*1024;
- misaligned: PADDR[log2(DATA_W/8)-1:0] != 0;
- read-only: write with offset < RO_BYTES.
REQ-030 An erroneous transfer SHALL still honour WAIT_STATES, then assert PSLVERR=1 with PREADY=1, with no memory write and PRDATA=0.
REQ-031 PSLVERR SHALL be 0 in every cycle except an erroring completing cycle.
REQ-032 Multiple errors in one transfer SHALL produce a single PSLVERR pulse.

Reset
REQ-033 PRESETn=0 SHALL, immediately and asynchronously, force FSM=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0.
REQ-034 Reset SHALL NOT clear memory contents.
REQ-035 Reset mid-transfer SHALL drop that transfer: no write, no completion.
REQ-036 The first setup accepted after release SHALL be one sampled with PRESETn=1.

Verification
REQ-037 Test configuration: DATA_W=64, BASE_ADDR=0x4000_0000, WAIT_STATES=2, RO_BYTES=0x100.
- Write 0x1122334455667788 to 0x4000_0200 with PSTRB=0xFF, then read it back.
- Required: each access phase lasts 3 cycles, PREADY low for 2 cycles, PRDATA=0x1122334455667788, PSLVERR=0.
REQ-038 Partial write: write 0xAAAAAAAAAAAAAAAA to 0x4000_0200 with PSTRB=0x0F, then read.
- Required: PRDATA=0x11223344AAAAAAAA.
REQ-039 Error cases, each with PSLVERR=1 and PREADY=1 on the 3rd access cycle:
- write to 0x4000_0080 (read-only): read-back of 0x4000_0080 unchanged;
- read from 0x4001_0000 (out-of-range): PRDATA=0;
- read from 0x4000_0204 (misaligned): PRDATA=0.
REQ-040 Abort: drop PSELx in the 2nd access cycle of a write to 0x4000_0300.
- Required: FSM returns to IDLE, no PREADY; read-back returns the prior value.
REQ-041 Reset: assert PRESETn mid-read.
- Required: PREADY, PSLVERR and PRDATA are 0 in the same cycle.
- After release, a read of 0x4000_0200 returns 0x11223344AAAAAAAA.
REQ-042 Back-to-back and zero-wait:
- Back-to-back reads with no idle cycle both complete correctly.
- Rerun with WAIT_STATES=0: PREADY=1 in the first access cycle.
